// File: rtl/cnn_seq_pkg.sv
// Shared types, error-bit indices and sizing helpers for the CNN frame sequencer.
package cnn_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StPad
    } seq_state_e;

    localparam int unsigned ErrLength   = 0;
    localparam int unsigned ErrTimeout  = 1;
    localparam int unsigned ErrSpurious = 2;

    // Wide enough for any class width; sliced down where it is used.
    localparam logic [31:0] TimeoutDecision = '1;

    function automatic int unsigned frame_pixels(input int unsigned width,
                                                 input int unsigned height);
        return width * height;
    endfunction

    // Bits needed to hold 0..n-1, never fewer than one.
    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cnn_result_fifo.sv
// Synchronous first-word-fall-through FIFO holding per-frame results.
module cnn_result_fifo
    import cnn_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PtrBits = cnt_bits(DEPTH);
    localparam int unsigned CntBits = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PtrBits-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntBits-1:0] count_q;
    logic               do_push, do_pop;

    function automatic logic [PtrBits-1:0] ptr_inc(input logic [PtrBits-1:0] p);
        return (p == PtrBits'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CntBits'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; the head is masked while empty instead.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign valid = (count_q != '0);
    assign rdata = valid ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Frame ingress/egress controller: feeds pixels to the CNN pipeline, tracks frames
// in flight with credits, and queues per-frame decisions for the consumer.
module cnn_frame_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int unsigned           PIXEL_BITS     = 8,
    parameter int unsigned           IMG_WIDTH      = 28,
    parameter int unsigned           IMG_HEIGHT     = 28,
    parameter int unsigned           CLASS_BITS     = 4,
    parameter int unsigned           ID_BITS        = 4,
    parameter int unsigned           MAX_INFLIGHT   = 2,
    parameter int unsigned           RESULT_DEPTH   = 4,
    parameter int unsigned           TIMEOUT_CYCLES = 4096,
    parameter logic [PIXEL_BITS-1:0] PAD_VALUE      = '0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [PIXEL_BITS-1:0]             s_data,
    input  logic                              s_valid,
    input  logic                              s_last,
    output logic                              s_ready,
    output logic [PIXEL_BITS-1:0]             pipe_data,
    output logic                              pipe_valid,
    input  logic [CLASS_BITS-1:0]             pipe_dec,
    input  logic                              pipe_dec_valid,
    output logic [CLASS_BITS-1:0]             m_decision,
    output logic [ID_BITS-1:0]                m_frame_id,
    output logic                              m_error,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic [2:0]                        err_sticky,
    output logic                              busy
);

    localparam int unsigned NPix      = frame_pixels(IMG_WIDTH, IMG_HEIGHT);
    localparam int unsigned PixBits   = $clog2(NPix + 1);
    localparam int unsigned InfBits   = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned CntBits   = $clog2(RESULT_DEPTH + 1);
    localparam int unsigned WdBits    = cnt_bits(TIMEOUT_CYCLES);
    localparam int unsigned SlotBits  = cnt_bits(MAX_INFLIGHT);
    localparam int unsigned EntryBits = CLASS_BITS + ID_BITS + 1;
    localparam logic [PixBits-1:0] LastPix = PixBits'(NPix - 1);

    seq_state_e             state_q;
    logic [PixBits-1:0]     pix_cnt_q, cur_idx;
    logic [InfBits-1:0]     inflight_q;
    logic [ID_BITS-1:0]     ret_id_q;
    logic [WdBits-1:0]      wd_cnt_q;
    logic [MAX_INFLIGHT-1:0] flag_q;
    logic [SlotBits-1:0]    flag_wr_q, flag_rd_q, cur_slot_q;
    logic [2:0]             err_q;
    logic                   pipe_valid_q;
    logic [PIXEL_BITS-1:0]  pipe_data_q;

    logic                   credit_ok, accept, start, at_last, early_last, len_err;
    logic                   dec_retire, wd_fire, retire, ret_flag, fifo_valid;
    logic [CntBits-1:0]     fifo_count;
    logic [EntryBits-1:0]   fifo_wdata, fifo_rdata;

    function automatic logic [SlotBits-1:0] slot_inc(input logic [SlotBits-1:0] s);
        return (s == SlotBits'(MAX_INFLIGHT - 1)) ? '0 : s + 1'b1;
    endfunction

    // Reserving a FIFO slot at frame start guarantees every retire can push.
    assign credit_ok = (32'(inflight_q) < MAX_INFLIGHT) &&
                       (32'(inflight_q) + 32'(fifo_count) < RESULT_DEPTH);
    assign s_ready   = rst_n && ((state_q == StStream) || ((state_q == StIdle) && credit_ok));
    assign accept    = s_valid && s_ready;
    assign start     = accept && (state_q == StIdle);
    assign cur_idx   = (state_q == StIdle) ? '0 : pix_cnt_q;
    assign at_last   = (cur_idx == LastPix);
    assign early_last = accept && s_last && !at_last;
    assign len_err   = early_last || (accept && at_last && !s_last);

    assign dec_retire = pipe_dec_valid && (inflight_q != '0);
    assign wd_fire    = !dec_retire && (inflight_q != '0) &&
                        (wd_cnt_q == WdBits'(TIMEOUT_CYCLES - 1));
    assign retire     = dec_retire || wd_fire;
    // Bypass a length flag raised in the same cycle its frame retires.
    assign ret_flag   = flag_q[flag_rd_q] || (len_err && !start && (cur_slot_q == flag_rd_q));
    assign fifo_wdata = dec_retire ? {pipe_dec, ret_id_q, ret_flag}
                                   : {TimeoutDecision[CLASS_BITS-1:0], ret_id_q, 1'b1};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pix_cnt_q    <= '0;
            inflight_q   <= '0;
            ret_id_q     <= '0;
            wd_cnt_q     <= '0;
            flag_q       <= '0;
            flag_wr_q    <= '0;
            flag_rd_q    <= '0;
            cur_slot_q   <= '0;
            err_q        <= '0;
            pipe_valid_q <= 1'b0;
            pipe_data_q  <= '0;
        end else begin
            pipe_valid_q <= 1'b0;
            pipe_data_q  <= '0;
            unique case (state_q)
                StIdle, StStream: begin
                    if (accept) begin
                        pipe_valid_q <= 1'b1;
                        pipe_data_q  <= s_data;
                        if (early_last) begin
                            state_q   <= StPad;
                            pix_cnt_q <= cur_idx + 1'b1;
                        end else if (at_last) begin
                            state_q   <= StIdle;
                            pix_cnt_q <= '0;
                        end else begin
                            state_q   <= StStream;
                            pix_cnt_q <= cur_idx + 1'b1;
                        end
                    end
                end
                StPad: begin
                    pipe_valid_q <= 1'b1;
                    pipe_data_q  <= PAD_VALUE;
                    if (pix_cnt_q == LastPix) begin
                        state_q   <= StIdle;
                        pix_cnt_q <= '0;
                    end else begin
                        pix_cnt_q <= pix_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (start) begin
                flag_q[flag_wr_q] <= len_err;
                cur_slot_q        <= flag_wr_q;
                flag_wr_q         <= slot_inc(flag_wr_q);
            end else if (len_err) begin
                flag_q[cur_slot_q] <= 1'b1;
            end

            unique case ({start, retire})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase

            if (retire) begin
                flag_rd_q <= slot_inc(flag_rd_q);
                ret_id_q  <= ret_id_q + 1'b1;
            end

            if (retire || (inflight_q == '0)) wd_cnt_q <= '0;
            else                              wd_cnt_q <= wd_cnt_q + 1'b1;

            if (len_err)                                   err_q[ErrLength]   <= 1'b1;
            if (wd_fire)                                   err_q[ErrTimeout]  <= 1'b1;
            if (pipe_dec_valid && (inflight_q == '0))      err_q[ErrSpurious] <= 1'b1;
        end
    end

    cnn_result_fifo #(
        .WIDTH (EntryBits),
        .DEPTH (RESULT_DEPTH)
    ) u_result_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (retire),
        .wdata (fifo_wdata),
        .pop   (m_ready),
        .rdata (fifo_rdata),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    assign {m_decision, m_frame_id, m_error} = fifo_rdata;
    assign m_valid    = fifo_valid;
    assign pipe_valid = pipe_valid_q;
    assign pipe_data  = pipe_data_q;
    assign inflight   = inflight_q;
    assign err_sticky = err_q;
    assign busy       = (state_q != StIdle) || (inflight_q != '0) || fifo_valid;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Randomized scoreboard bench for cnn_frame_sequencer with a small image size.
module tb_cnn_frame_sequencer;

    localparam int unsigned W = 4, H = 3, NPIX = W * H;
    localparam int unsigned TMO = 200;
    localparam logic [7:0]  PAD_V = 8'h5A;

    logic       clk, rst_n;
    logic [7:0] s_data, pipe_data;
    logic       s_valid, s_last, s_ready, pipe_valid;
    logic [3:0] pipe_dec, m_decision, m_frame_id;
    logic       pipe_dec_valid, m_error, m_valid, m_ready, busy;
    logic [1:0] inflight;
    logic [2:0] err_sticky;

    cnn_frame_sequencer #(
        .PIXEL_BITS(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .CLASS_BITS(4), .ID_BITS(4),
        .MAX_INFLIGHT(2), .RESULT_DEPTH(4), .TIMEOUT_CYCLES(TMO), .PAD_VALUE(PAD_V)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .pipe_data(pipe_data), .pipe_valid(pipe_valid),
        .pipe_dec(pipe_dec), .pipe_dec_valid(pipe_dec_valid), .m_decision(m_decision),
        .m_frame_id(m_frame_id), .m_error(m_error), .m_valid(m_valid), .m_ready(m_ready),
        .inflight(inflight), .err_sticky(err_sticky), .busy(busy)
    );

    int checks = 0, errors = 0, cyc = 0;
    logic [7:0] exp_pix[$];
    logic [8:0] exp_res[$];
    bit         frame_err[$];
    int         pend_due[$];
    bit         pend_err[$];
    int         strobe_cnt = 0, mready_prob = 70;
    bit         hold_mready = 0, drop_next = 0, late_dec_req = 0, any_len = 0;
    logic [3:0] next_id = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    // Pipeline model: checks strobes in order, answers each completed frame.
    initial begin : pipe_model
        logic [7:0] p;
        logic [3:0] dv;
        bit         e;
        pipe_dec_valid = 0;
        pipe_dec = 0;
        forever begin
            @(negedge clk);
            pipe_dec_valid = 0;
            if (pipe_valid) begin
                if (exp_pix.size() == 0) begin
                    check("pipe_unexpected_strobe", {24'd0, pipe_data}, 32'hFFFF_FFFF);
                end else begin
                    p = exp_pix.pop_front();
                    check("pipe_data", {24'd0, pipe_data}, {24'd0, p});
                end
                strobe_cnt++;
                if (strobe_cnt == NPIX) begin
                    strobe_cnt = 0;
                    e = (frame_err.size() != 0) ? frame_err.pop_front() : 1'b0;
                    if (drop_next) begin
                        drop_next = 0;
                        exp_res.push_back({4'hF, next_id, 1'b1});
                        next_id++;
                    end else begin
                        pend_due.push_back(cyc + int'($urandom_range(0, 8)));
                        pend_err.push_back(e);
                    end
                end
            end
            if (late_dec_req) begin
                late_dec_req = 0;
                pipe_dec = 4'($urandom);
                pipe_dec_valid = 1;
            end else if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
                void'(pend_due.pop_front());
                e = pend_err.pop_front();
                dv = 4'($urandom);
                pipe_dec = dv;
                pipe_dec_valid = 1;
                exp_res.push_back({dv, next_id, e});
                next_id++;
            end
        end
    end

    // Result monitor: drives m_ready and pops the scoreboard on each handshake.
    initial begin : monitor
        logic [8:0] r;
        m_ready = 0;
        forever begin
            @(negedge clk);
            m_ready = hold_mready ? 1'b0 : (int'($urandom_range(0, 99)) < mready_prob);
            if (m_valid && m_ready) begin
                if (exp_res.size() == 0) begin
                    check("result_unexpected", {23'd0, m_decision, m_frame_id, m_error},
                          32'hFFFF_FFFF);
                end else begin
                    r = exp_res.pop_front();
                    check("result", {23'd0, m_decision, m_frame_id, m_error}, {23'd0, r});
                end
            end
        end
    end

    task automatic send_frame(input int len, input bit has_last, input int vprob);
        int i = 0, waitc = 0;
        logic [7:0] d = 8'($urandom);
        frame_err.push_back((len != NPIX) || !has_last);
        while (i < len) begin
            @(negedge clk);
            s_valid = (int'($urandom_range(0, 99)) < vprob);
            s_data  = d;
            s_last  = has_last && (i == len - 1);
            if (s_valid && s_ready) begin
                exp_pix.push_back(d);
                i++;
                waitc = 0;
                d = 8'($urandom);
                if (i == len && has_last)
                    for (int k = len; k < NPIX; k++) exp_pix.push_back(PAD_V);
            end else if (++waitc > 1000) begin
                check("s_ready_timeout", {31'd0, s_ready}, 32'd1);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 0;
            s_last  = 0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_pix.size() != 0 || frame_err.size() != 0 || pend_due.size() != 0 ||
                exp_res.size() != 0 || busy) && n < 3000) begin
            idle(1);
            n++;
        end
        check("drain_busy", {31'd0, busy}, 32'd0);
        check("drain_results_left", exp_res.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
        check({tag, "_pipe_valid"}, {31'd0, pipe_valid}, 32'd0);
        check({tag, "_pipe_data"}, {24'd0, pipe_data}, 32'd0);
        check({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
        check({tag, "_m_head"}, {23'd0, m_decision, m_frame_id, m_error}, 32'd0);
        check({tag, "_inflight"}, {30'd0, inflight}, 32'd0);
        check({tag, "_err_sticky"}, {29'd0, err_sticky}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin : main
        int r, n;
        rst_n = 0; s_valid = 0; s_last = 0; s_data = 0;
        idle(3);
        check_reset_outputs("reset");
        @(negedge clk) rst_n = 1;

        // Random mix of good, short (padded) and overlong frames.
        for (int f = 0; f < 40; f++) begin
            mready_prob = int'($urandom_range(5, 100));
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                any_len = 1;
                send_frame(int'($urandom_range(1, NPIX - 1)), 1'b1, int'($urandom_range(60, 100)));
            end else if (r == 2) begin
                any_len = 1;
                send_frame(NPIX, 1'b0, int'($urandom_range(60, 100)));
            end else begin
                send_frame(NPIX, 1'b1, int'($urandom_range(60, 100)));
            end
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 5)));
        end
        idle(1);
        mready_prob = 70;
        wait_drain();
        check("random_err_sticky", {29'd0, err_sticky}, {29'd0, 2'b00, any_len});

        // Consumer stalled: four results fill the FIFO, the fifth frame must wait.
        hold_mready = 1;
        for (int f = 0; f < 4; f++) send_frame(NPIX, 1'b1, 100);
        idle(1);
        n = 0;
        while ((frame_err.size() != 0 || pend_due.size() != 0 || exp_res.size() != 4) &&
               n < 500) begin
            idle(1);
            n++;
        end
        check("stall_results_queued", exp_res.size(), 32'd4);
        fork
            send_frame(NPIX, 1'b1, 100);
        join_none
        repeat (20) @(negedge clk);
        check("stall_s_ready", {31'd0, s_ready}, 32'd0);
        check("stall_m_valid", {31'd0, m_valid}, 32'd1);
        check("stall_inflight", {30'd0, inflight}, 32'd0);
        hold_mready = 0;
        wait fork;
        idle(1);
        wait_drain();

        // Lost decision: watchdog retires the frame, then a late strobe is spurious.
        drop_next = 1;
        send_frame(NPIX, 1'b1, 100);
        idle(1);
        wait_drain();
        check("timeout_inflight", {30'd0, inflight}, 32'd0);
        check("timeout_err_sticky", {29'd0, err_sticky}, {29'd0, 2'b01, any_len});
        late_dec_req = 1;
        idle(4);
        check("spurious_err_sticky", {29'd0, err_sticky}, {29'd0, 2'b11, any_len});
        check("spurious_dropped", {31'd0, m_valid}, 32'd0);

        // Reset in the middle of a frame discards it; ids restart from zero.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            s_valid = 1; s_last = 0; s_data = 8'(k + 1);
            if (s_ready) exp_pix.push_back(8'(k + 1));
        end
        idle(1);
        @(negedge clk);
        rst_n = 0;
        exp_pix.delete();
        strobe_cnt = 0;
        next_id = 0;
        any_len = 0;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst_n = 1;
        send_frame(NPIX, 1'b1, 100);
        idle(1);
        wait_drain();
        check("final_err_sticky", {29'd0, err_sticky}, 32'd0);
        check("final_next_id", {28'd0, next_id}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
